demux2_reg: RTL and testbench
=============================

Name: demux2_reg

Overview:
- Registered 1-to-2 demultiplexer with valid/ready handshake on every side; it is the distributing counterpart of the two-input select mux used throughout the pipeline.
- Routes one producer word to one of two consumers, e.g. the MEM-stage store path split between data memory (channel 0) and MMIO peripherals (channel 1).
- Each output channel has a one-entry register, giving one cycle of latency with full throughput.
- Each channel has a transfer counter for debug.

Parameters:
- bits, 32: data width of the input and both output channels.
- CNT_W, 8: width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of both output slots (pipeline flush).
- DataIn  input  bits  producer data.
- Signal  input  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- DataOut0  output  bits  channel 0 data.
- out_valid0  output  1  channel 0 slot holds a word.
- out_ready0  input  1  channel 0 consumer takes the word.
- DataOut1  output  bits  channel 1 data.
- out_valid1  output  1  channel 1 slot holds a word.
- out_ready1  input  1  channel 1 consumer takes the word.
- cnt0  output  CNT_W  completed channel 0 output transfers.
- cnt1  output  CNT_W  completed channel 1 output transfers.

Behaviour:
- Reset (rstn low, asynchronous): both slots empty, out_valid0/1 = 0, DataOut0/1 = 0, cnt0/1 = 0. This holds whenever rstn is low, including mid-transfer; the word in flight is lost.
- Per-channel state: full_k flag and data_k register. out_valid_k = full_k; DataOut_k = data_k.
- in_ready is combinational:
  - flush = 1: in_ready = 0.
  - Signal = 0: in_ready = !full0 | out_ready0.
  - Signal = 1: in_ready = !full1 | out_ready1.
- accept = in_valid & in_ready.
- Producer rule: once in_valid is high, the producer holds in_valid, DataIn and Signal stable until accept.
- Consumer rule: while out_valid_k is high and not taken, DataOut_k is held stable.
- Slot update, per channel k, at each rising clk (priority order):
  1. flush: full_k <= 0; data_k is held.
  2. accept & Signal == k: full_k <= 1, data_k <= DataIn. This applies whether or not the old word drains in the same cycle (simultaneous drain + load keeps full_k = 1 with the new data).
  3. full_k & out_ready_k: full_k <= 0.
  4. Otherwise hold.
- Latency: a word accepted in cycle N is visible on out_valid_k / DataOut_k in cycle N+1.
- Throughput: 1 word per cycle while the selected consumer keeps out_ready_k high.
- Channel independence: a stalled channel blocks only inputs selected to it. The other channel keeps draining independently.
- out_ready_k while out_valid_k = 0 has no effect.
- Counters: cnt_k increments when full_k & out_ready_k & !flush. A flushed word is not counted. Counters wrap from 2^CNT_W-1 to 0. flush does not clear the counters; only reset does.
- No combinational path from DataIn to DataOut_k.
- in_ready depends combinationally on Signal, flush and out_ready_k. This path is documented; the producer must not make in_valid depend on in_ready.

Test Plan:
- Reset, then a single word: rstn low then high; in_valid = 1, Signal = 0, DataIn = 0x0000_00A5 for one cycle with out_ready0 = 1 → next cycle out_valid0 = 1, DataOut0 = 0x0000_00A5, out_valid1 = 0; the following cycle out_valid0 = 0 and cnt0 = 1.
- Back-pressure and hold: out_ready1 = 0; send 0x11 then 0x22 to channel 1 → 0x11 is accepted; in_ready stays 0 for 0x22 while DataOut1 holds 0x11. Raise out_ready1 → 0x11 drains and 0x22 is accepted in the same cycle (full1 stays 1); DataOut1 = 0x22 next cycle.
- Streaming: 10 back-to-back words alternating Signal 0/1, both out_ready high → in_ready stays 1 throughout; each word appears on its channel exactly 1 cycle later; cnt0 = 5, cnt1 = 5.
- Channel independence: out_ready0 = 0 with slot 0 full; send 0x33 with Signal = 1 → accepted immediately and delivered on channel 1; slot 0 still holds its word.
- Flush: both slots full, assert flush for one cycle → in_ready = 0 that cycle; both out_valid = 0 next cycle; counters unchanged.
- Async reset and wrap: assert rstn low mid-stream with both slots full → outputs clear immediately without a clock edge. Separately, perform 256 channel 0 transfers → cnt0 wraps to 0.

Source files
------------

// File: rtl/demux2_if.sv
// Handshake bundle for the registered 1-to-2 demultiplexer: one producer side, two consumer channels.
// The master modport is the environment (producer plus both consumers); the slave modport is the demux.
interface demux2_if #(
    parameter int bits = 32
);
    logic [bits-1:0] DataIn;
    logic            Signal;
    logic            in_valid;
    logic            in_ready;

    logic [bits-1:0] DataOut0;
    logic            out_valid0;
    logic            out_ready0;

    logic [bits-1:0] DataOut1;
    logic            out_valid1;
    logic            out_ready1;

    modport master (
        output DataIn,
        output Signal,
        output in_valid,
        input  in_ready,
        input  DataOut0,
        input  out_valid0,
        output out_ready0,
        input  DataOut1,
        input  out_valid1,
        output out_ready1
    );

    modport slave (
        input  DataIn,
        input  Signal,
        input  in_valid,
        output in_ready,
        output DataOut0,
        output out_valid0,
        input  out_ready0,
        output DataOut1,
        output out_valid1,
        input  out_ready1
    );
endinterface

// File: rtl/demux2_reg.sv
// Registered 1-to-2 demultiplexer: each channel owns a one-entry output slot (one cycle latency,
// full throughput) and a wrapping transfer counter for debug.
module demux2_reg #(
    parameter int bits  = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    demux2_if.slave          bus,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);

    logic            full0_p1;
    logic            full1_p1;
    logic [bits-1:0] data0_p1;
    logic [bits-1:0] data1_p1;
    logic [CNT_W-1:0] cnt0_p1;
    logic [CNT_W-1:0] cnt1_p1;

    logic inReady;
    logic accept;
    logic load0;
    logic load1;
    logic drain0;
    logic drain1;

    // in_ready looks only at the selected slot, so a stalled channel never blocks the other one.
    always_comb begin
        inReady = 1'b0;
        if (!flush) begin
            if (bus.Signal) inReady = !full1_p1 || bus.out_ready1;
            else            inReady = !full0_p1 || bus.out_ready0;
        end
    end

    always_comb begin
        accept = bus.in_valid && inReady;
        load0  = accept && !bus.Signal;
        load1  = accept &&  bus.Signal;
        drain0 = full0_p1 && bus.out_ready0;
        drain1 = full1_p1 && bus.out_ready1;
    end

    // ---- stage p0 -> p1: output slot registers ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full0_p1 <= 1'b0;
            data0_p1 <= '0;
        end else if (flush) begin
            full0_p1 <= 1'b0;
        end else if (load0) begin
            full0_p1 <= 1'b1;
            data0_p1 <= bus.DataIn;
        end else if (drain0) begin
            full0_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            full1_p1 <= 1'b0;
            data1_p1 <= '0;
        end else if (flush) begin
            full1_p1 <= 1'b0;
        end else if (load1) begin
            full1_p1 <= 1'b1;
            data1_p1 <= bus.DataIn;
        end else if (drain1) begin
            full1_p1 <= 1'b0;
        end
    end

    // A word dropped by flush never completed its transfer, so it is not counted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt0_p1 <= '0;
            cnt1_p1 <= '0;
        end else if (!flush) begin
            if (drain0) cnt0_p1 <= cnt0_p1 + 1'b1;
            if (drain1) cnt1_p1 <= cnt1_p1 + 1'b1;
        end
    end

    assign bus.in_ready   = inReady;
    assign bus.out_valid0 = full0_p1;
    assign bus.DataOut0   = data0_p1;
    assign bus.out_valid1 = full1_p1;
    assign bus.DataOut1   = data1_p1;
    assign cnt0           = cnt0_p1;
    assign cnt1           = cnt1_p1;

endmodule

// File: tb/tb_demux2_reg.sv
// Self-checking bench for demux2_reg: directed scenarios plus a randomized run, all checked
// against a queue-based model of the two output slots and their transfer counts.
module tb_demux2_reg;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    demux2_if #(.bits(32)) bus ();

    demux2_reg #(.bits(32), .CNT_W(8)) dut (
        .clk  (clk),
        .rstn (rstn),
        .flush(flush),
        .bus  (bus),
        .cnt0 (cnt0),
        .cnt1 (cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: words currently held per channel (at most one each) and completed transfer counts.
    logic [31:0] pend0[$];
    logic [31:0] pend1[$];
    logic [7:0]  mCnt0;
    logic [7:0]  mCnt1;

    function automatic logic expReady();
        if (flush) return 1'b0;
        if (bus.Signal) return (pend1.size() == 0) || bus.out_ready1;
        return (pend0.size() == 0) || bus.out_ready0;
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic r0, input logic r1, input logic f);
        bus.in_valid   = v;
        bus.Signal     = s;
        bus.DataIn     = d;
        bus.out_ready0 = r0;
        bus.out_ready1 = r1;
        flush          = f;
        #1;
    endtask

    // Advance one clock (called just after a negedge) and apply the spec rules to the model.
    task automatic tick();
        logic acc, sel, f, r0, r1;
        logic [31:0] d;
        acc = bus.in_valid && expReady();
        sel = bus.Signal;
        d   = bus.DataIn;
        f   = flush;
        r0  = bus.out_ready0;
        r1  = bus.out_ready1;
        @(posedge clk);
        if (f) begin
            pend0.delete();
            pend1.delete();
        end else begin
            if (r0 && pend0.size() != 0) begin void'(pend0.pop_front()); mCnt0 = mCnt0 + 8'd1; end
            if (r1 && pend1.size() != 0) begin void'(pend1.pop_front()); mCnt1 = mCnt1 + 8'd1; end
            if (acc) begin
                if (sel) pend1.push_back(d);
                else     pend0.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic modelReset();
        pend0.delete();
        pend1.delete();
        mCnt0 = 8'd0;
        mCnt1 = 8'd0;
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rstn = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_valid0: got %b expected 0", bus.out_valid0); end
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL reset_valid1: got %b expected 0", bus.out_valid1); end
        checks++; if (bus.DataOut0 !== 32'h0) begin errors++; $display("FAIL reset_data0: got %h expected 0", bus.DataOut0); end
        checks++; if (bus.DataOut1 !== 32'h0) begin errors++; $display("FAIL reset_data1: got %h expected 0", bus.DataOut1); end
        checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        drive(1'b1, 1'b0, 32'h0000_00A5, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", bus.in_ready); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        checks++; if (bus.out_valid0 !== 1'b1 || bus.DataOut0 !== 32'h0000_00A5) begin errors++; $display("FAIL single_out0: got %b/%h expected 1/000000a5", bus.out_valid0, bus.DataOut0); end
        checks++; if (bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL single_valid1: got %b expected 0", bus.out_valid1); end
        tick();
        checks++; if (bus.out_valid0 !== 1'b0 || cnt0 !== 8'd1) begin errors++; $display("FAIL single_drain: got valid %b cnt %0d expected 0/1", bus.out_valid0, cnt0); end
    endtask

    task automatic test_backpressure();
        drive(1'b1, 1'b1, 32'h11, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0", bus.in_ready); end
            checks++; if (bus.out_valid1 !== 1'b1 || bus.DataOut1 !== 32'h11) begin errors++; $display("FAIL bp_hold: got %b/%h expected 1/00000011", bus.out_valid1, bus.DataOut1); end
            tick();
        end
        drive(1'b1, 1'b1, 32'h22, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", bus.in_ready); end
        tick();
        drive(1'b0, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid1 !== 1'b1 || bus.DataOut1 !== 32'h22) begin errors++; $display("FAIL bp_reload: got %b/%h expected 1/00000022", bus.out_valid1, bus.DataOut1); end
        checks++; if (cnt1 !== mCnt1) begin errors++; $display("FAIL bp_cnt1: got %0d expected %0d", cnt1, mCnt1); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_stream();
        logic [7:0] base0, base1;
        logic [31:0] w;
        base0 = mCnt0;
        base1 = mCnt1;
        for (int i = 0; i < 10; i++) begin
            w = $urandom;
            drive(1'b1, i[0], w, 1'b1, 1'b1, 1'b0);
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, bus.in_ready); end
            tick();
            if (i[0]) begin
                checks++; if (bus.out_valid1 !== 1'b1 || bus.DataOut1 !== w) begin errors++; $display("FAIL stream_out1[%0d]: got %b/%h expected 1/%h", i, bus.out_valid1, bus.DataOut1, w); end
            end else begin
                checks++; if (bus.out_valid0 !== 1'b1 || bus.DataOut0 !== w) begin errors++; $display("FAIL stream_out0[%0d]: got %b/%h expected 1/%h", i, bus.out_valid0, bus.DataOut0, w); end
            end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
        checks++; if (cnt0 !== base0 + 8'd5) begin errors++; $display("FAIL stream_cnt0: got %0d expected %0d", cnt0, base0 + 8'd5); end
        checks++; if (cnt1 !== base1 + 8'd5) begin errors++; $display("FAIL stream_cnt1: got %0d expected %0d", cnt1, base1 + 8'd5); end
    endtask

    task automatic test_independence();
        drive(1'b1, 1'b0, 32'h44, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h33, 1'b0, 1'b1, 1'b0);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL indep_ready: got %b expected 1", bus.in_ready); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        checks++; if (bus.out_valid1 !== 1'b1 || bus.DataOut1 !== 32'h33) begin errors++; $display("FAIL indep_out1: got %b/%h expected 1/00000033", bus.out_valid1, bus.DataOut1); end
        checks++; if (bus.out_valid0 !== 1'b1 || bus.DataOut0 !== 32'h44) begin errors++; $display("FAIL indep_hold0: got %b/%h expected 1/00000044", bus.out_valid0, bus.DataOut0); end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        tick();
    endtask

    task automatic test_flush();
        logic [7:0] c0, c1;
        drive(1'b1, 1'b0, 32'h55, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        tick();
        c0 = mCnt0;
        c1 = mCnt1;
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", bus.in_ready); end
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        checks++; if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b/%b expected 0/0", bus.out_valid0, bus.out_valid1); end
        checks++; if (cnt0 !== c0 || cnt1 !== c1) begin errors++; $display("FAIL flush_cnt: got %0d/%0d expected %0d/%0d", cnt0, cnt1, c0, c1); end
    endtask

    task automatic test_async_reset();
        drive(1'b1, 1'b0, 32'h77, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #2 rstn = 1'b0;
        #1;
        modelReset();
        checks++; if (bus.out_valid0 !== 1'b0 || bus.out_valid1 !== 1'b0) begin errors++; $display("FAIL areset_valid: got %b/%b expected 0/0", bus.out_valid0, bus.out_valid1); end
        checks++; if (bus.DataOut0 !== 32'h0 || bus.DataOut1 !== 32'h0) begin errors++; $display("FAIL areset_data: got %h/%h expected 0/0", bus.DataOut0, bus.DataOut1); end
        checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd0) begin errors++; $display("FAIL areset_cnt: got %0d/%0d expected 0/0", cnt0, cnt1); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, 1'b0, $urandom, 1'b1, 1'b0, 1'b0);
            tick();
            checks++; if (cnt0 !== mCnt0) begin errors++; $display("FAIL wrap_cnt0[%0d]: got %0d expected %0d", i, cnt0, mCnt0); end
        end
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL wrap_final: got %0d expected 0", cnt0); end
    endtask

    task automatic test_random();
        logic v, s, r0, r1, f, hold;
        logic [31:0] d;
        hold = 1'b0;
        v = 1'b0; s = 1'b0; d = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                s = 1'($urandom_range(0, 1));
                d = $urandom;
            end
            r0 = ($urandom_range(0, 3) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            f  = ($urandom_range(0, 19) == 0);
            drive(v, s, d, r0, r1, f);
            checks++; if (bus.in_ready !== expReady()) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, bus.in_ready, expReady()); end
            checks++; if (bus.out_valid0 !== (pend0.size() != 0)) begin errors++; $display("FAIL rand_valid0[%0d]: got %b expected %b", i, bus.out_valid0, pend0.size() != 0); end
            checks++; if (bus.out_valid1 !== (pend1.size() != 0)) begin errors++; $display("FAIL rand_valid1[%0d]: got %b expected %b", i, bus.out_valid1, pend1.size() != 0); end
            if (pend0.size() != 0) begin
                checks++; if (bus.DataOut0 !== pend0[0]) begin errors++; $display("FAIL rand_data0[%0d]: got %h expected %h", i, bus.DataOut0, pend0[0]); end
            end
            if (pend1.size() != 0) begin
                checks++; if (bus.DataOut1 !== pend1[0]) begin errors++; $display("FAIL rand_data1[%0d]: got %h expected %h", i, bus.DataOut1, pend1[0]); end
            end
            checks++; if (cnt0 !== mCnt0 || cnt1 !== mCnt1) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d/%0d expected %0d/%0d", i, cnt0, cnt1, mCnt0, mCnt1); end
            hold = v && !expReady();
            tick();
        end
    endtask

    initial begin
        rstn  = 1'b0;
        flush = 1'b0;
        bus.in_valid   = 1'b0;
        bus.Signal     = 1'b0;
        bus.DataIn     = 32'h0;
        bus.out_ready0 = 1'b0;
        bus.out_ready1 = 1'b0;
        modelReset();
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_independence();
        test_flush();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
